uart_rx_os16: RTL and testbench
===============================

UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per oversample tick (range 1..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of two, 2..16).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port rx  input  1  serial line, 8N1, idle high, asynchronous to clk.
REQ-006 The block SHALL have port data_out  output  8  byte at FIFO head.
REQ-007 The block SHALL have port data_valid  output  1  FIFO non-empty, data_out valid.
REQ-008 The block SHALL have port data_ready  input  1  consumer accepts data_out when data_valid is high.
REQ-009 The block SHALL have port frame_err  output  1  one-clk pulse on a bad stop bit.
REQ-010 The block SHALL have port overrun  output  1  one-clk pulse when a good byte is dropped because the FIFO is full.
REQ-011 The block SHALL have port busy  output  1  high while the FSM is not IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer, both flops reset to 1; all logic uses the synchronized value.
REQ-013 Tick counter SHALL count 0..CLK_DIV-1 and assert tick for one clk when it equals CLK_DIV-1; it free-runs; one bit = 16 ticks.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; sample counter 0..15 advances on tick.
REQ-015 IDLE: on a tick with synchronized rx=0 -> START, sample counter cleared to 0.
REQ-016 Each bit value SHALL be the majority of the samples taken at sample counts 7, 8 and 9.
REQ-017 START: majority 1 -> IDLE (false start, no output); else at sample count 15 -> DATA.
REQ-018 DATA: 8 bits, LSB first, shifted into an 8-bit register; after bit 7 at sample count 15 -> STOP.
REQ-019 STOP: decision at sample count 9, then -> IDLE immediately (no wait for full stop bit).
REQ-020 Stop majority 1 -> push byte into FIFO; stop majority 0 -> frame_err pulse, byte discarded.
REQ-021 Push with FIFO full and no pop in the same cycle -> byte dropped, overrun pulse, FIFO unchanged.
REQ-022 Push and pop in the same cycle SHALL both occur, including when full; no overrun in that case.
REQ-023 Pop occurs when data_valid and data_ready are both high; data_out SHALL hold while data_valid and not data_ready.
REQ-024 data_valid SHALL rise on the clk after the push cycle; bytes delivered in arrival order.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-026 frame_err and overrun SHALL be mutually exclusive, each at most one pulse per frame.

Reset
REQ-027 While reset=0: FSM=IDLE, tick and sample counters=0, shift register=0, FIFO empty, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output; the first falling edge after release starts a new frame.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, the OVERSAMPLE=16 constant and the sample indices 7/8/9.
REQ-030 The FIFO SHALL be a separate sub-module uart_byte_fifo (push/pop/full/empty/head); the FSM, synchronizer and tick logic stay in uart_rx_os16.

Verification (CLK_DIV=4, 64 clk/bit)
REQ-031 Send 0xA1 with data_ready=1 -> data_valid one clk, data_out=0xA1, no frame_err or overrun.
REQ-032 Drive rx low for 3 ticks then high -> back to IDLE, busy drops, no data_valid, no error pulse.
REQ-033 Send 0x55 with stop bit 0 -> one frame_err pulse, data_valid stays 0.
REQ-034 data_ready=0, send 0x11..0x55 back-to-back -> one overrun pulse on 0x55; set data_ready=1 -> drains 0x11, 0x22, 0x33, 0x44 in order.
REQ-035 Assert reset during bit 4 of 0xC3, release, send 0x3A -> all outputs reset values during reset, then only 0x3A delivered.
REQ-036 Ten back-to-back frames 0xA1..0x3A, data_ready=1, one rx sample flipped at sample count 8 in each bit -> all ten bytes correct by majority vote.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 16x oversampling UART receiver: FSM states,
// oversample constants and the 2-of-3 majority vote used per bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] SAMPLE_A    = 4'd7;
  localparam logic [3:0] SAMPLE_B    = 4'd8;
  localparam logic [3:0] SAMPLE_C    = 4'd9;
  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

  // 2-of-3 vote; a single corrupted sample cannot change the bit value
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous byte FIFO. Head is presented combinationally and forced
// to zero while empty so the consumer never sees stale storage.
module uart_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              push_e;
  logic              pop_e;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign pop_e  = pop & ~empty;
  assign push_e = push & (~full | pop_e);
  assign head   = empty ? '0 : mem[rptr];

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (push_e) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_e) wptr <= wptr + PW'(1);
      if (pop_e)  rptr <= rptr + PW'(1);
      case ({push_e, pop_e})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, majority-voted bit samples and a
// small output FIFO. Stop bit is judged at its centre so back-to-back frames
// resynchronise on every start edge.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          rx_s1;
  logic          rx_sync;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  rx_state_t     state;
  logic [3:0]    sample_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          samp_a;
  logic          samp_b;
  logic          bit_val;
  logic          push_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign tick       = (tick_cnt == TW'(CLK_DIV - 1));
  assign bit_val    = majority3(samp_a, samp_b, rx_sync);
  assign busy       = (state != IDLE);
  assign data_valid = ~fifo_empty;
  assign pop        = data_valid & data_ready;

  // Two-flop synchronizer; idles high so reset looks like a quiet line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_sync <= rx_s1;
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + TW'(1);
  end

  // Capture the first two vote samples; the third is the live synchronized value
  always_ff @(posedge clk) begin
    if (tick && state != IDLE) begin
      if (sample_cnt == SAMPLE_A) samp_a <= rx_sync;
      if (sample_cnt == SAMPLE_B) samp_b <= rx_sync;
    end
  end

  // Receive FSM: start validation, LSB-first data shift, mid-stop decision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      frame_err  <= 1'b0;
      push_req   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      push_req  <= 1'b0;
      if (tick) begin
        if (state != IDLE) sample_cnt <= sample_cnt + 4'd1;
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state      <= START;
              sample_cnt <= '0;
            end
          end
          START: begin
            if (sample_cnt == SAMPLE_C && bit_val) begin
              state <= IDLE;
            end else if (sample_cnt == SAMPLE_LAST) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
          DATA: begin
            if (sample_cnt == SAMPLE_C) shift_reg <= {bit_val, shift_reg[7:1]};
            if (sample_cnt == SAMPLE_LAST) begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end
          end
          STOP: begin
            if (sample_cnt == SAMPLE_C) begin
              state <= IDLE;
              if (bit_val) push_req  <= 1'b1;
              else         frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Overrun flags a good byte that arrived with no room and no simultaneous pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun <= 1'b0;
    else overrun <= push_req & fifo_full & ~pop;
  end

  uart_byte_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (shift_reg),
    .pop       (pop),
    .head      (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at CLK_DIV=4 (64 clk per bit).
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vcyc = 0;

  always #5 clk = ~clk;

  uart_rx_os16 #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Observation of accepted bytes and pulse counts, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      if (data_valid && data_ready) got.push_back(data_out);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (data_valid) vcyc++;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic glitch);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (glitch) begin
        repeat (35) @(posedge clk);
        #1 rx = ~bits[i];
        repeat (4) @(posedge clk);
        #1 rx = bits[i];
        repeat (25) @(posedge clk);
        #1;
      end else begin
        repeat (64) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_single_byte();
    int base, fe0, ov0, v0;
    logic [7:0] b;
    data_ready = 1'b1;
    base = got.size(); fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
    send_frame(8'hA1, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    b = (got.size() > base) ? got[base] : 8'hxx;
    vectors++; if (got.size() - base != 1) begin miscompares++; $display("FAIL a1_count: got %0d expected 1", got.size() - base); end
    vectors++; if (b !== 8'hA1) begin miscompares++; $display("FAIL a1_data: got %h expected a1", b); end
    vectors++; if (vcyc - v0 != 1) begin miscompares++; $display("FAIL a1_valid_cycles: got %0d expected 1", vcyc - v0); end
    vectors++; if (fe_cnt - fe0 != 0) begin miscompares++; $display("FAIL a1_frame_err: got %0d expected 0", fe_cnt - fe0); end
    vectors++; if (ov_cnt - ov0 != 0) begin miscompares++; $display("FAIL a1_overrun: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_false_start();
    int fe0, ov0, v0;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL false_start_busy_high: got %b expected 1", busy); end
    repeat (6) @(posedge clk);
    #1 rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL false_start_busy_low: got %b expected 0", busy); end
    vectors++; if (vcyc - v0 != 0) begin miscompares++; $display("FAIL false_start_valid: got %0d expected 0", vcyc - v0); end
    vectors++; if (fe_cnt - fe0 != 0) begin miscompares++; $display("FAIL false_start_frame_err: got %0d expected 0", fe_cnt - fe0); end
    vectors++; if (ov_cnt - ov0 != 0) begin miscompares++; $display("FAIL false_start_overrun: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_frame_error();
    int fe0, ov0, v0;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    vectors++; if (fe_cnt - fe0 != 1) begin miscompares++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
    vectors++; if (vcyc - v0 != 0) begin miscompares++; $display("FAIL ferr_valid: got %0d expected 0", vcyc - v0); end
    vectors++; if (ov_cnt - ov0 != 0) begin miscompares++; $display("FAIL ferr_overrun: got %0d expected 0", ov_cnt - ov0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_busy: got %b expected 0", busy); end
  endtask

  task automatic test_overrun();
    int base, fe0, ov0;
    logic [7:0] exp_b [4];
    logic [7:0] b;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    data_ready = 1'b0;
    base = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (data_out !== 8'h11) begin miscompares++; $display("FAIL ovr_hold_early: got %h expected 11", data_out); end
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (ov_cnt - ov0 != 1) begin miscompares++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt - ov0); end
    vectors++; if (fe_cnt - fe0 != 0) begin miscompares++; $display("FAIL ovr_frame_err: got %0d expected 0", fe_cnt - fe0); end
    vectors++; if (data_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid_held: got %b expected 1", data_valid); end
    vectors++; if (data_out !== 8'h11) begin miscompares++; $display("FAIL ovr_hold_late: got %h expected 11", data_out); end
    data_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (got.size() - base != 4) begin miscompares++; $display("FAIL ovr_drain_count: got %0d expected 4", got.size() - base); end
    for (int i = 0; i < 4; i++) begin
      b = (got.size() > base + i) ? got[base + i] : 8'hxx;
      vectors++; if (b !== exp_b[i]) begin miscompares++; $display("FAIL ovr_drain_%0d: got %h expected %h", i, b, exp_b[i]); end
    end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drained_valid: got %b expected 0", data_valid); end
  endtask

  task automatic test_reset_mid_frame();
    int base, fe0, ov0;
    logic [9:0] bits;
    logic [7:0] b;
    data_ready = 1'b1;
    bits = {1'b1, 8'hC3, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      repeat ((i < 4) ? 64 : 30) @(posedge clk);
      #1;
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL midrst_data_out: got %h expected 00", data_out); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_data_valid: got %b expected 0", data_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    reset = 1'b1;
    base = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (40) @(posedge clk);
    send_frame(8'h3A, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    b = (got.size() > base) ? got[base] : 8'hxx;
    vectors++; if (got.size() - base != 1) begin miscompares++; $display("FAIL midrst_count: got %0d expected 1", got.size() - base); end
    vectors++; if (b !== 8'h3A) begin miscompares++; $display("FAIL midrst_data: got %h expected 3a", b); end
    vectors++; if (fe_cnt - fe0 != 0) begin miscompares++; $display("FAIL midrst_ferr_after: got %0d expected 0", fe_cnt - fe0); end
    vectors++; if (ov_cnt - ov0 != 0) begin miscompares++; $display("FAIL midrst_ovr_after: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_back_to_back();
    int base, fe0;
    logic [7:0] exp_b [10];
    logic [7:0] b;
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h29, 8'h3A};
    data_ready = 1'b1;
    base = got.size(); fe0 = fe_cnt;
    for (int i = 0; i < 10; i++) send_frame(exp_b[i], 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    vectors++; if (got.size() - base != 10) begin miscompares++; $display("FAIL b2b_count: got %0d expected 10", got.size() - base); end
    for (int i = 0; i < 10; i++) begin
      b = (got.size() > base + i) ? got[base + i] : 8'hxx;
      vectors++; if (b !== exp_b[i]) begin miscompares++; $display("FAIL b2b_byte_%0d: got %h expected %h", i, b, exp_b[i]); end
    end
    vectors++; if (fe_cnt - fe0 != 0) begin miscompares++; $display("FAIL b2b_frame_err: got %0d expected 0", fe_cnt - fe0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
